// File: rtl/pipe_cla_addsub_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor.
//   flags_t    : compare/carry flags reported alongside each result
//   calc_nblk  : number of lookahead blocks (= pipeline stages) for a width
//   cfg_ok     : legality of a WIDTH/BLOCK pairing, checked at elaboration
package pipe_cla_addsub_pkg;

  localparam int MAX_BLOCK = 16;

  typedef struct packed {
    logic cout;
    logic ne;
    logic lt;
    logic ltu;
    logic of;
  } flags_t;

  function automatic int calc_nblk(input int width, input int block);
    return width / block;
  endfunction

  // Width must split into whole blocks, and a block must stay small enough
  // that its flattened lookahead fits in one clock period.
  function automatic bit cfg_ok(input int width, input int block);
    return (block >= 1) && (block <= MAX_BLOCK) && (width >= block) &&
           ((width % block) == 0);
  endfunction

endpackage

// File: rtl/pipe_cla_addsub_cla_block.sv
// cla_block: one BLOCK-bit carry-lookahead adder slice.
//   a, b : operand slices
//   cin  : carry into bit 0
//   sum  : a + b + cin (low BLOCK bits)
//   cout : carry out of the top bit
module cla_block #(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout
);

  logic [BLOCK-1:0] w_g;
  logic [BLOCK-1:0] w_p;
  logic [BLOCK:0]   w_c;
  logic             w_term;
  logic             w_pp;

  assign w_g = a & b;
  assign w_p = a | b;

  // Every carry is a flat sum of products of g/p and cin, so no carry
  // depends on another carry:
  //   c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]cin
  always_comb begin
    w_c    = '0;
    w_term = 1'b0;
    w_pp   = 1'b1;
    w_c[0] = cin;
    for (int i = 0; i < BLOCK; i++) begin
      w_term = 1'b0;
      w_pp   = 1'b1;
      for (int j = i; j >= 0; j--) begin
        w_term = w_term | (w_g[j] & w_pp);
        w_pp   = w_pp & w_p[j];
      end
      w_c[i+1] = w_term | (cin & w_pp);
    end
  end

  assign sum  = a ^ b ^ w_c[BLOCK-1:0];
  assign cout = w_c[BLOCK];

endmodule

// File: rtl/pipe_cla_addsub.sv
// pipe_cla_addsub: pipelined carry-lookahead adder/subtractor, one
// BLOCK-bit lookahead block per stage, WIDTH/BLOCK stages.
//   clock, reset          : rising-edge clock, async active-high reset
//   in_valid/in_ready     : operation handshake (in_ready = pipe advances)
//   in_a, in_b, in_sub    : operands; in_sub=1 computes A + ~B + 1
//   in_tag                : opaque tag carried with the operation
//   out_valid/out_ready   : result handshake; all stages hold while stalled
//   out_sum, out_cout     : result modulo 2^WIDTH and carry out of the MSB
//   out_ne/lt/ltu/of      : nonzero, signed/unsigned less-than, overflow
//   out_tag               : tag of the presented result
module pipe_cla_addsub
  import pipe_cla_addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ne,
  output logic             out_lt,
  output logic             out_ltu,
  output logic             out_of,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NBLK = calc_nblk(WIDTH, BLOCK);
  localparam int L    = NBLK - 1;

  if (!cfg_ok(WIDTH, BLOCK)) begin : g_bad_cfg
    $error("pipe_cla_addsub: WIDTH must be a multiple of BLOCK and BLOCK <= 16");
  end

  logic   w_advance;
  logic   w_of;
  flags_t w_flags;

  // One global enable: the whole pipe shifts (bubbles included) or holds.
  assign w_advance = ~out_valid | out_ready;
  assign in_ready  = w_advance;

  for (genvar k = 0; k < NBLK; k++) begin : g_stage
    // Stage k consumes operand bits [k*BLOCK +: BLOCK]. It keeps the
    // still-unconsumed upper operand bits; the last stage keeps only the
    // operand MSBs, which the overflow flag needs.
    localparam int IN_W   = WIDTH - k*BLOCK;
    localparam int LO     = (k == NBLK-1) ? WIDTH-1 : (k+1)*BLOCK;
    localparam int KEEP_W = WIDTH - LO;
    localparam int SUM_W  = (k+1)*BLOCK;

    logic [IN_W-1:0]   w_a_in;
    logic [IN_W-1:0]   w_b_in;
    logic              w_cin;
    logic              w_sub_in;
    logic              w_vld_in;
    logic [TAG_W-1:0]  w_tag_in;
    logic [SUM_W-1:0]  w_sum_nxt;
    logic [BLOCK-1:0]  w_blk_sum;
    logic              w_blk_cout;

    logic [KEEP_W-1:0] r_a;
    logic [KEEP_W-1:0] r_b;
    logic [SUM_W-1:0]  r_sum;
    logic              r_c;
    logic              r_sub;
    logic              r_vld;
    logic [TAG_W-1:0]  r_tag;

    if (k == 0) begin : g_head
      // B is inverted once on entry; the +1 of the subtract rides in as cin.
      assign w_a_in    = in_a;
      assign w_b_in    = in_sub ? ~in_b : in_b;
      assign w_cin     = in_sub;
      assign w_sub_in  = in_sub;
      assign w_vld_in  = in_valid;
      assign w_tag_in  = in_tag;
      assign w_sum_nxt = w_blk_sum;
    end else begin : g_body
      assign w_a_in    = g_stage[k-1].r_a;
      assign w_b_in    = g_stage[k-1].r_b;
      assign w_cin     = g_stage[k-1].r_c;
      assign w_sub_in  = g_stage[k-1].r_sub;
      assign w_vld_in  = g_stage[k-1].r_vld;
      assign w_tag_in  = g_stage[k-1].r_tag;
      assign w_sum_nxt = {w_blk_sum, g_stage[k-1].r_sum};
    end

    cla_block #(.BLOCK(BLOCK)) u_cla (
      .a    (w_a_in[BLOCK-1:0]),
      .b    (w_b_in[BLOCK-1:0]),
      .cin  (w_cin),
      .sum  (w_blk_sum),
      .cout (w_blk_cout)
    );

    // ---- stage k register boundary ----
    always_ff @(posedge clock or posedge reset) begin
      if (reset)          r_vld <= 1'b0;
      else if (w_advance) r_vld <= w_vld_in;
    end

    always_ff @(posedge clock) begin
      if (w_advance) begin
        r_a   <= w_a_in[IN_W-1 -: KEEP_W];
        r_b   <= w_b_in[IN_W-1 -: KEEP_W];
        r_sum <= w_sum_nxt;
        r_c   <= w_blk_cout;
        r_sub <= w_sub_in;
        r_tag <= w_tag_in;
      end
    end
  end

  assign out_valid = g_stage[L].r_vld;

  // Overflow of the effective operands A and B' (B or ~B).
  assign w_of = (~g_stage[L].r_a[0] & ~g_stage[L].r_b[0] &  g_stage[L].r_sum[WIDTH-1]) |
                ( g_stage[L].r_a[0] &  g_stage[L].r_b[0] & ~g_stage[L].r_sum[WIDTH-1]);

  // Data registers carry no reset, so outputs are forced to zero whenever
  // no result is present; this also gives all-zero outputs after reset.
  always_comb begin
    out_sum = '0;
    out_tag = '0;
    w_flags = '0;
    if (out_valid) begin
      out_sum      = g_stage[L].r_sum;
      out_tag      = g_stage[L].r_tag;
      w_flags.cout = g_stage[L].r_c;
      w_flags.ne   = |g_stage[L].r_sum;
      w_flags.of   = w_of;
      w_flags.lt   = g_stage[L].r_sum[WIDTH-1] ^ w_of;
      w_flags.ltu  = g_stage[L].r_sub & ~g_stage[L].r_c;
    end
  end

  assign out_cout = w_flags.cout;
  assign out_ne   = w_flags.ne;
  assign out_lt   = w_flags.lt;
  assign out_ltu  = w_flags.ltu;
  assign out_of   = w_flags.of;

endmodule

// File: tb/tb_pipe_cla_addsub.sv
// Bench for pipe_cla_addsub: three configurations (32/8, 12/4, 16/16) share
// clock and reset; results are compared against an arithmetic A +/- B model.
module tb_pipe_cla_addsub;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ne;
    logic        lt;
    logic        ltu;
    logic        of;
    logic [4:0]  tag;
  } res_t;

  int WD [3] = '{32, 12, 16};
  int NB [3] = '{4, 3, 1};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0][31:0] ia, ib;
  logic [2:0][4:0]  itg;
  logic [2:0]       iv, isub, ordy;
  wire  [2:0][31:0] sm;
  wire  [2:0][4:0]  tg;
  wire  [2:0]       ov, ir, fc, fne, flt, fltu, fof;

  assign sm[1][31:12] = '0;
  assign sm[2][31:16] = '0;

  pipe_cla_addsub u_d0 (
    .clock(clk), .reset(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_a(ia[0]), .in_b(ib[0]), .in_sub(isub[0]), .in_tag(itg[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_sum(sm[0]), .out_cout(fc[0]),
    .out_ne(fne[0]), .out_lt(flt[0]), .out_ltu(fltu[0]), .out_of(fof[0]),
    .out_tag(tg[0]));

  pipe_cla_addsub #(.WIDTH(12), .BLOCK(4), .TAG_W(5)) u_d1 (
    .clock(clk), .reset(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_a(ia[1][11:0]), .in_b(ib[1][11:0]), .in_sub(isub[1]), .in_tag(itg[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_sum(sm[1][11:0]), .out_cout(fc[1]),
    .out_ne(fne[1]), .out_lt(flt[1]), .out_ltu(fltu[1]), .out_of(fof[1]),
    .out_tag(tg[1]));

  pipe_cla_addsub #(.WIDTH(16), .BLOCK(16), .TAG_W(5)) u_d2 (
    .clock(clk), .reset(rst), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_a(ia[2][15:0]), .in_b(ib[2][15:0]), .in_sub(isub[2]), .in_tag(itg[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_sum(sm[2][15:0]), .out_cout(fc[2]),
    .out_ne(fne[2]), .out_lt(flt[2]), .out_ltu(fltu[2]), .out_of(fof[2]),
    .out_tag(tg[2]));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: true integer arithmetic, reduced to w bits afterwards.
  function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic s, input logic [4:0] t);
    res_t   r;
    longint mask, ua, ub, sa, sb, sr, lim;
    mask = (longint'(1) << w) - 1;
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    sa   = a[w-1] ? ua - (longint'(1) << w) : ua;
    sb   = b[w-1] ? ub - (longint'(1) << w) : ub;
    if (s) begin
      r.sum  = 32'((ua - ub) & mask);
      r.cout = (ua >= ub);
      sr     = sa - sb;
    end else begin
      r.sum  = 32'((ua + ub) & mask);
      r.cout = ((ua + ub) > mask);
      sr     = sa + sb;
    end
    lim   = longint'(1) << (w - 1);
    r.of  = (sr >= lim) || (sr < -lim);
    r.lt  = (sr < 0);
    r.ltu = s && (ua < ub);
    r.ne  = (r.sum != 0);
    r.tag = t;
    return r;
  endfunction

  function automatic res_t observe(input int k);
    res_t r;
    r.sum = sm[k]; r.cout = fc[k]; r.ne = fne[k]; r.lt = flt[k];
    r.ltu = fltu[k]; r.of = fof[k]; r.tag = tg[k];
    return r;
  endfunction

  function automatic logic [31:0] rnd_op(input int w);
    logic [31:0] m, v;
    m = 32'((longint'(1) << w) - 1);
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = m;
      2:       v = m >> 1;
      3:       v = (m >> 1) + 1;
      default: v = $urandom;
    endcase
    return v & m;
  endfunction

  task automatic cmp_res(input int k, input res_t o, input res_t e);
    chk_eq($sformatf("d%0d_sum", k),  o.sum,  e.sum);
    chk_eq($sformatf("d%0d_cout", k), o.cout, e.cout);
    chk_eq($sformatf("d%0d_ne", k),   o.ne,   e.ne);
    chk_eq($sformatf("d%0d_lt", k),   o.lt,   e.lt);
    chk_eq($sformatf("d%0d_ltu", k),  o.ltu,  e.ltu);
    chk_eq($sformatf("d%0d_of", k),   o.of,   e.of);
    chk_eq($sformatf("d%0d_tag", k),  o.tag,  e.tag);
  endtask

  // Issue one op into an idle pipe and wait (bounded) for its result.
  task automatic op_single(input int k, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [4:0] t,
                           output res_t o, output int lat);
    @(negedge clk);
    ordy[k] = 1'b1; ia[k] = a; ib[k] = b; isub[k] = s; itg[k] = t; iv[k] = 1'b1;
    #1 chk_eq($sformatf("d%0d_idle_in_ready", k), ir[k], 1);
    @(posedge clk);
    #1 iv[k] = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (ov[k]) break;
    end
    o = observe(k);
  endtask

  // mode 0: back-to-back, always ready; mode 1: ready low for 3 cycles
  // mid-stream; mode 2: random valid/ready with random tags.
  task automatic run_stream(input int k, input int n, input int mode);
    res_t        q[$];
    res_t        e, o, held;
    logic        held_v;
    logic [31:0] a, b;
    logic        s;
    logic [4:0]  t;
    int          sent, got, last;
    sent = 0; got = 0; last = -1; held_v = 1'b0; held = '0;
    a = rnd_op(WD[k]); b = rnd_op(WD[k]); s = 1'($urandom_range(0, 1));
    t = (mode == 2) ? 5'($urandom) : 5'(sent);
    for (int c = 0; got < n && c < n*8 + 100; c++) begin
      @(negedge clk);
      case (mode)
        0:       ordy[k] = 1'b1;
        1:       ordy[k] = !(c >= 6 && c < 9);
        default: ordy[k] = ($urandom_range(0, 4) != 0);
      endcase
      if (sent < n) begin
        ia[k] = a; ib[k] = b; isub[k] = s; itg[k] = t;
        iv[k] = (mode == 2) ? ($urandom_range(0, 4) != 0) : 1'b1;
      end else begin
        iv[k] = 1'b0;
      end
      #1;
      if (ov[k]) begin
        o = observe(k);
        if (held_v) begin
          chk_eq("hold_sum", o.sum, held.sum);
          chk_eq("hold_tag", o.tag, held.tag);
          chk_eq("hold_flags", {o.cout, o.ne, o.lt, o.ltu, o.of},
                 {held.cout, held.ne, held.lt, held.ltu, held.of});
        end
        if (ordy[k]) begin
          held_v = 1'b0;
          chk_eq("sb_nonempty", q.size() > 0, 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            cmp_res(k, o, e);
            if (mode == 0) chk_eq("stream_cycle", c, (last < 0) ? NB[k] : last + 1);
            last = c;
            got++;
          end
        end else begin
          chk_eq("stall_in_ready", ir[k], 0);
          held   = o;
          held_v = 1'b1;
        end
      end
      if (iv[k] && ir[k]) begin
        q.push_back(model(WD[k], a, b, s, t));
        sent++;
        a = rnd_op(WD[k]); b = rnd_op(WD[k]); s = 1'($urandom_range(0, 1));
        t = (mode == 2) ? 5'($urandom) : 5'(sent);
      end
    end
    chk_eq($sformatf("d%0d_stream_count", k), got, n);
    chk_eq($sformatf("d%0d_stream_left", k), q.size(), 0);
    @(negedge clk);
    iv[k] = 1'b0; ordy[k] = 1'b1;
  endtask

  initial begin
    res_t o, e;
    int   lat, seen;
    rst = 1'b1; iv = '0; ordy = '1; isub = '0; ia = '0; ib = '0; itg = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk_eq($sformatf("d%0d_rst_valid", k), ov[k], 0);
      chk_eq($sformatf("d%0d_rst_ready", k), ir[k], 1);
      chk_eq($sformatf("d%0d_rst_outs", k), observe(k), '0);
    end

    // Directed cases on the default configuration.
    op_single(0, 32'h7FFF_FFFF, 32'h1, 1'b0, 5'd3, o, lat);
    chk_eq("ovf_lat", lat, 4);
    chk_eq("ovf_sum", o.sum, 32'h8000_0000);
    chk_eq("ovf_of", o.of, 1); chk_eq("ovf_cout", o.cout, 0);
    chk_eq("ovf_lt", o.lt, 0); chk_eq("ovf_ne", o.ne, 1);
    chk_eq("ovf_ltu", o.ltu, 0); chk_eq("ovf_tag", o.tag, 3);

    op_single(0, 32'd5, 32'd7, 1'b1, 5'd4, o, lat);
    chk_eq("sub57_sum", o.sum, 32'hFFFF_FFFE);
    chk_eq("sub57_lt", o.lt, 1); chk_eq("sub57_ltu", o.ltu, 1);
    chk_eq("sub57_of", o.of, 0); chk_eq("sub57_ne", o.ne, 1);

    op_single(0, 32'd7, 32'd7, 1'b1, 5'd5, o, lat);
    chk_eq("sub77_sum", o.sum, 0); chk_eq("sub77_ne", o.ne, 0);
    chk_eq("sub77_cout", o.cout, 1); chk_eq("sub77_ltu", o.ltu, 0);

    op_single(0, 32'h00FF_FFFF, 32'h1, 1'b0, 5'd6, o, lat);
    chk_eq("carry24_sum", o.sum, 32'h0100_0000); chk_eq("carry24_cout", o.cout, 0);

    op_single(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 5'd7, o, lat);
    chk_eq("carry32_sum", o.sum, 0); chk_eq("carry32_cout", o.cout, 1);
    chk_eq("carry32_ne", o.ne, 0);

    // Latency of the other configurations.
    op_single(1, 32'h7FF, 32'h001, 1'b0, 5'd9, o, lat);
    chk_eq("d1_lat", lat, 3);
    cmp_res(1, o, model(12, 32'h7FF, 32'h001, 1'b0, 5'd9));
    op_single(2, 32'h0003, 32'h8000, 1'b1, 5'd10, o, lat);
    chk_eq("d2_lat", lat, 1);
    cmp_res(2, o, model(16, 32'h0003, 32'h8000, 1'b1, 5'd10));

    // Streaming, then a stall mid-stream.
    run_stream(0, 8, 0);
    run_stream(0, 12, 1);

    // Reset with three ops in flight.
    @(negedge clk);
    ordy[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ia[0] = $urandom; ib[0] = $urandom; isub[0] = 1'b0; itg[0] = 5'(20 + i); iv[0] = 1'b1;
      @(negedge clk);
    end
    iv[0] = 1'b0;
    @(posedge clk);
    #1 chk_eq("pre_rst_valid", ov[0], 1);
    #1 rst = 1'b1;
    #1;
    chk_eq("mid_rst_valid", ov[0], 0);
    chk_eq("mid_rst_outs", observe(0), '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk_eq("post_rst_ready", ir[0], 1);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (ov[0]) seen++;
    end
    chk_eq("rst_no_ghosts", seen, 0);
    op_single(0, 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 5'd17, o, lat);
    chk_eq("post_rst_lat", lat, 4);
    cmp_res(0, o, model(32, 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 5'd17));

    // Random sweeps with random backpressure.
    run_stream(1, 10000, 2);
    run_stream(2, 10000, 2);
    run_stream(0, 3000, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_cla_addsub.md
# pipe_cla_addsub

Parametrised, pipelined carry-lookahead adder/subtractor for the processor datapath. It generalises the fixed 32-bit CLA with 8-bit blocks to any width and block size. One block is resolved per pipeline stage, so the clock period is bounded by a single block. A valid/ready handshake with backpressure lets ALU and multiply/divide sequencers stream one operation per cycle. Each result carries add/sub mode, a pass-through tag, and signed/unsigned compare flags.

## Interface
- WIDTH, 32, operand width; must be a multiple of BLOCK, and WIDTH ≥ BLOCK.
- BLOCK, 8, bits resolved per stage by one lookahead block.
- TAG_W, 5, width of the opaque tag carried alongside each operation (e.g. destination register).
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted this cycle when in_valid && in_ready.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_sub  in  1  0: A+B; 1: A−B (computed as A + ~B + 1).
- in_tag  in  TAG_W  passed through unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH  sum/difference, wraps modulo 2^WIDTH.
- out_cout  out  1  carry out of the MSB.
- out_ne  out  1  out_sum ≠ 0.
- out_lt  out  1  signed less-than: out_sum[MSB] ^ out_of.
- out_ltu  out  1  unsigned less-than: ~out_cout when the operation was a subtract; 0 for adds.
- out_of  out  1  signed overflow of the effective operands (A, B' = B or ~B).
- out_tag  out  TAG_W  tag of this result.

## Operation
- NBLK = WIDTH/BLOCK pipeline stages. Stage k computes bits [k·BLOCK +: BLOCK] using the carry registered by stage k−1. Stage 0 uses cin = in_sub.
- Per stage:
  - Registers hold the remaining operand slices, the partial sum, the running carry, the sub bit, the tag and a valid bit.
  - Already-computed sum slices advance unchanged.
- Flags are computed combinationally from the final stage's registers:
  - out_of = (~A[MSB] & ~B'[MSB] & S[MSB]) | (A[MSB] & B'[MSB] & ~S[MSB]).
- Global stall: advance = ~out_valid | out_ready.
  - When advance is high, every stage shifts, and bubbles shift too.
  - When advance is low, all stages hold.
  - in_ready = advance.
- Bubbles are never reported: out_valid is the valid bit of the last stage.
- Results leave in issue order. Tags and the sub bit stay aligned with their operands.

## Timing
- Latency is NBLK cycles from the accepting edge to out_valid, with no stall. The default configuration gives 4 cycles.
- Throughput is 1 op/cycle while out_ready stays high.
- During a stall, out_* are held stable until the edge where out_valid && out_ready.
- The case out_valid=1, out_ready=1, in_valid=1 is a simultaneous retire and accept: both happen in the same cycle, with no bubble inserted.
- When out_ready is low and the pipe is full, in_ready=0 and new inputs are ignored.
- Reset, including when asserted mid-operation:
  - All valid bits clear immediately and in-flight ops are discarded.
  - out_valid=0, out_sum=0, out_tag=0, all flags=0, in_ready=1 after reset deassertion.
- NBLK=1 degenerates to a single registered stage with latency 1.

## Structure
- A shared package holds:
  - the flag struct (cout, ne, lt, ltu, of);
  - a function computing NBLK;
  - elaboration-time checks that WIDTH % BLOCK == 0 and BLOCK ≤ 16.
- Sub-module cla_block, parametrised by BLOCK:
  - inputs a, b, cin; outputs sum, cout;
  - internal per-bit generate g = a&b and propagate p = a|b, with full lookahead carries.
  - It is instantiated once per stage via generate.
- The top level contains only the stage registers, the handshake and the flag logic.

## Test plan
- Add, default params: 0x7FFFFFFF + 0x00000001, tag 3.
  - After 4 cycles: sum 0x80000000, of=1, cout=0, lt=0 (0x80000000 is negative and of=1, so lt = 1^1 = 0), ne=1, tag 3.
- Subtract compare: 5 − 7.
  - sum 0xFFFFFFFE, lt=1, ltu=1, of=0, ne=1.
  - Then 7 − 7 gives sum 0, ne=0, cout=1, ltu=0.
- Carry across every block: 0x00FFFFFF + 1.
  - sum 0x01000000, cout=0.
  - Then 0xFFFFFFFF + 1 gives sum 0, cout=1, ne=0.
- Streaming: 8 back-to-back ops with out_ready=1.
  - Results on 8 consecutive cycles, in order, tags 0..7.
  - Then hold out_ready=0 for 3 cycles mid-stream: in_ready=0, out_* stable, no loss or duplication.
- Reset mid-flight: assert reset with 3 ops in the pipe.
  - out_valid drops immediately and none of the 3 ops emerges.
  - The next op after release emerges after exactly 4 cycles.
- Parameter sweep: WIDTH=12/BLOCK=4 and WIDTH=16/BLOCK=16.
  - 10k random ops are checked against a behavioural A±B model for sum and all flags.
  - Latencies are 3 and 1 cycles respectively.
